// File: rtl/seq_detect_moore_pkg.sv
// Shared definitions for the serial pattern detector: legal ranges, mode enum, KMP step.
// Latency: n/a (package only; seqdet_next is purely combinational).
// Backpressure: n/a.
package seqdet_pkg;

   // Legal parameter ranges for the detector.
   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;
   localparam int CNT_W_MIN = 1;
   localparam int CNT_W_MAX = 32;

   // Detection mode after a full match.
   typedef enum logic {
      MODE_NON_OVERLAP = 1'b0,
      MODE_OVERLAP     = 1'b1
   } mode_e;

   // Next matched-prefix length after shifting in din from prefix length k.
   // pattern is right-aligned in PAT_W_MAX bits; bit pat_w-1 is the first bit received.
   // The matched prefix is therefore pattern[pat_w-1 -: k], and the candidate string is
   // that prefix followed by din. Returns the longest j <= min(k+1, pat_w) such that the
   // first j pattern bits equal the last j bits of the candidate string. From the full
   // match state in non-overlap mode the search restarts as if from an empty prefix.
   function automatic int unsigned seqdet_next(
      input logic [PAT_W_MAX-1:0] pattern,
      input int unsigned          pat_w,
      input int unsigned          k,
      input logic                 din,
      input logic                 overlap
   );
      int unsigned          k_eff;
      int unsigned          j_max;
      int unsigned          best;
      int unsigned          idx;
      logic [PAT_W_MAX-1:0] sh;
      logic                 pbit;
      logic                 sbit;
      logic                 ok;

      k_eff = (k >= pat_w && !overlap) ? 32'd0 : k;
      j_max = (k_eff + 1 > pat_w) ? pat_w : k_eff + 1;
      best  = 0;

      for (int unsigned j = 1; j <= PAT_W_MAX; j++) begin
         if (j <= j_max) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < PAT_W_MAX; i++) begin
               if (i < j) begin
                  // i-th bit of the pattern prefix of length j
                  sh   = pattern >> (pat_w - 1 - i);
                  pbit = sh[0];
                  // matching position inside (prefix, din); last position is din itself
                  idx  = k_eff + 1 - j + i;
                  if (idx == k_eff) begin
                     sbit = din;
                  end else begin
                     sh   = pattern >> (pat_w - 1 - idx);
                     sbit = sh[0];
                  end
                  if (pbit != sbit) begin
                     ok = 1'b0;
                  end
               end
            end
            if (ok) begin
               best = j;
            end
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_detect_moore_if.sv
// Signal bundle between the serial data path and the pattern detector.
// Latency: n/a (wires only).
// Backpressure: none; din_valid qualifies din and the detector always accepts.
interface seq_detect_moore_if
   import seqdet_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) ();

   localparam int STATE_W = $clog2(PAT_W + 1);

   // configuration
   logic               cfg_load;
   logic [PAT_W-1:0]   cfg_pattern;
   logic               cfg_overlap;
   // serial data
   logic               din_valid;
   logic               din;
   // statistics control
   logic               cnt_clr;
   // results
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic [STATE_W-1:0] state_o;

   // Source side: drives configuration, data and counter clear; observes results.
   modport master (
      output cfg_load,
      output cfg_pattern,
      output cfg_overlap,
      output din_valid,
      output din,
      output cnt_clr,
      input  match,
      input  match_cnt,
      input  state_o
   );

   // Detector side.
   modport slave (
      input  cfg_load,
      input  cfg_pattern,
      input  cfg_overlap,
      input  din_valid,
      input  din,
      input  cnt_clr,
      output match,
      output match_cnt,
      output state_o
   );

endinterface

// File: rtl/seq_detect_moore_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
// Latency: count reflects inc/clr one clock after the edge that samples them.
// Backpressure: none; holds at all-ones once saturated.
module seqdet_sat_counter
   import seqdet_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("seqdet_sat_counter: CNT_W out of legal range");
   end

   // Next count: clear wins, otherwise step unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/seq_detect_moore.sv
// Runtime-programmable serial pattern detector (Moore FSM over matched-prefix length).
// Latency: match/match_cnt update one clock after the edge sampling the final pattern bit.
// Backpressure: none; bits only advance on din_valid, state holds otherwise.
module seq_detect_moore
   import seqdet_pkg::*;
#(
   parameter int               PAT_W       = 4,
   parameter int               CNT_W       = 8,
   parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1011,
   parameter logic             RST_OVERLAP = 1'b1
) (
   input logic               clk,
   input logic               reset,
   seq_detect_moore_if.slave bus
);

   localparam int STATE_W = $clog2(PAT_W + 1);

   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_detect_moore: PAT_W out of legal range");
   end

   logic [PAT_W-1:0]   pattern_q;
   mode_e              mode_q;
   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic               match_q;
   logic               match_d;
   int unsigned        nxt_len;
   logic [CNT_W-1:0]   cnt_val;

   // Next state and next match: a config load resets the FSM and swallows any
   // coincident data bit; otherwise a valid bit takes the KMP step.
   always_comb begin
      nxt_len = seqdet_next(PAT_W_MAX'(pattern_q), unsigned'(PAT_W), 32'(state_q),
                            bus.din, mode_q == MODE_OVERLAP);
      state_d = state_q;
      match_d = 1'b0;
      if (bus.cfg_load) begin
         state_d = '0;
      end else if (bus.din_valid) begin
         state_d = STATE_W'(nxt_len);
         match_d = (nxt_len == unsigned'(PAT_W));
      end
   end

   // Pattern/mode registers, prefix-length FSM and the registered match pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern_q <= RST_PATTERN;
         mode_q    <= mode_e'(RST_OVERLAP);
         state_q   <= '0;
         match_q   <= 1'b0;
      end else begin
         if (bus.cfg_load) begin
            pattern_q <= bus.cfg_pattern;
            mode_q    <= mode_e'(bus.cfg_overlap);
         end
         state_q <= state_d;
         match_q <= match_d;
      end
   end

   // Match statistics; increments on the same edge that raises match.
   seqdet_sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match_d),
      .clr   (bus.cnt_clr),
      .count (cnt_val)
   );

   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_val;
   assign bus.state_o   = state_q;

endmodule

// File: tb/tb_seq_detect_moore.sv
module tb_seq_detect_moore;

   logic       clk;
   logic       reset;
   logic       cfg_load;
   logic [3:0] cfg_pattern;
   logic       cfg_overlap;
   logic       din_valid;
   logic       din;
   logic       cnt_clr;

   int checks;
   int errors;

   seq_detect_moore_if #(.PAT_W(4), .CNT_W(8)) ia ();
   seq_detect_moore_if #(.PAT_W(4), .CNT_W(2)) ib ();

   assign ia.cfg_load    = cfg_load;
   assign ia.cfg_pattern = cfg_pattern;
   assign ia.cfg_overlap = cfg_overlap;
   assign ia.din_valid   = din_valid;
   assign ia.din         = din;
   assign ia.cnt_clr     = cnt_clr;
   assign ib.cfg_load    = cfg_load;
   assign ib.cfg_pattern = cfg_pattern;
   assign ib.cfg_overlap = cfg_overlap;
   assign ib.din_valid   = din_valid;
   assign ib.din         = din;
   assign ib.cnt_clr     = cnt_clr;

   seq_detect_moore #(
      .PAT_W(4), .CNT_W(8), .RST_PATTERN(4'b1011), .RST_OVERLAP(1'b1)
   ) u_dut_a (
      .clk(clk), .reset(reset), .bus(ia)
   );

   seq_detect_moore #(
      .PAT_W(4), .CNT_W(2), .RST_PATTERN(4'b1011), .RST_OVERLAP(1'b1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .bus(ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b);
      din_valid = 1'b1;
      din       = b;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_cfg(input logic [3:0] p, input logic ov, input logic clr);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_overlap = ov;
      cnt_clr     = clr;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
   endtask

   task automatic test_reset;
      logic [3:0] bits;
      logic [3:0] em;
      checks++;
      if (ia.match !== 1'b0 || ia.match_cnt !== 8'd0 || ia.state_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_values: got match=%0b cnt=%0d state=%0d required 0/0/0",
                  ia.match, ia.match_cnt, ia.state_o);
      end
      reset = 1'b0;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      checks++;
      if (ia.state_o !== 3'd3) begin
         errors++;
         $display("FAIL reset_prefix101: got state=%0d required 3", ia.state_o);
      end
      reset = 1'b1;
      #2;
      checks++;
      if (ia.match !== 1'b0 || ia.match_cnt !== 8'd0 || ia.state_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_midstream: got match=%0b cnt=%0d state=%0d required 0/0/0",
                  ia.match, ia.match_cnt, ia.state_o);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      bits = 4'b1011;
      em   = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         send_bit(bits[3-i]);
         checks++;
         if (ia.match !== em[3-i]) begin
            errors++;
            $display("FAIL reset_rerun_match bit%0d: got %0b required %0b", i, ia.match, em[3-i]);
         end
      end
      checks++;
      if (ia.match_cnt !== 8'd1) begin
         errors++;
         $display("FAIL reset_rerun_cnt: got %0d required 1", ia.match_cnt);
      end
      idle(1);
      checks++;
      if (ia.match !== 1'b0 || ia.match_cnt !== 8'd1) begin
         errors++;
         $display("FAIL reset_rerun_after: got match=%0b cnt=%0d required 0/1",
                  ia.match, ia.match_cnt);
      end
   endtask

   task automatic test_overlap;
      logic [6:0] bits;
      logic [6:0] em;
      int         es[7];
      bits = 7'b1011011;
      em   = 7'b0001001;
      es   = '{1, 2, 3, 4, 2, 3, 4};
      do_cfg(4'b1011, 1'b1, 1'b1);
      checks++;
      if (ia.match_cnt !== 8'd0 || ia.state_o !== 3'd0) begin
         errors++;
         $display("FAIL ovl_cfg: got cnt=%0d state=%0d required 0/0", ia.match_cnt, ia.state_o);
      end
      for (int i = 0; i < 7; i++) begin
         send_bit(bits[6-i]);
         checks++;
         if (ia.state_o !== 3'(es[i]) || ia.match !== em[6-i]) begin
            errors++;
            $display("FAIL ovl_step bit%0d: got state=%0d match=%0b required %0d/%0b",
                     i, ia.state_o, ia.match, es[i], em[6-i]);
         end
      end
      checks++;
      if (ia.match_cnt !== 8'd2) begin
         errors++;
         $display("FAIL ovl_cnt: got %0d required 2", ia.match_cnt);
      end
   endtask

   task automatic test_non_overlap;
      logic [10:0] bits;
      logic [10:0] em;
      int          es[11];
      bits = 11'b10110111011;
      em   = 11'b00010000001;
      es   = '{1, 2, 3, 4, 0, 1, 1, 1, 2, 3, 4};
      do_cfg(4'b1011, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) begin
         send_bit(bits[10-i]);
         checks++;
         if (ia.state_o !== 3'(es[i]) || ia.match !== em[10-i]) begin
            errors++;
            $display("FAIL novl_step bit%0d: got state=%0d match=%0b required %0d/%0b",
                     i, ia.state_o, ia.match, es[i], em[10-i]);
         end
         if (i == 6) begin
            checks++;
            if (ia.match_cnt !== 8'd1) begin
               errors++;
               $display("FAIL novl_cnt_first: got %0d required 1", ia.match_cnt);
            end
         end
      end
      checks++;
      if (ia.match_cnt !== 8'd2) begin
         errors++;
         $display("FAIL novl_cnt_second: got %0d required 2", ia.match_cnt);
      end
   endtask

   task automatic test_valid_gaps;
      logic [3:0] bits;
      int         gaps[4];
      int         es[4];
      bits = 4'b1011;
      gaps = '{1, 2, 3, 0};
      es   = '{1, 2, 3, 4};
      do_cfg(4'b1011, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_bit(bits[3-i]);
         checks++;
         if (ia.state_o !== 3'(es[i]) || ia.match !== (i == 3)) begin
            errors++;
            $display("FAIL gap_bit bit%0d: got state=%0d match=%0b required %0d/%0b",
                     i, ia.state_o, ia.match, es[i], (i == 3));
         end
         for (int g = 0; g < gaps[i]; g++) begin
            idle(1);
            checks++;
            if (ia.state_o !== 3'(es[i]) || ia.match !== 1'b0) begin
               errors++;
               $display("FAIL gap_hold bit%0d gap%0d: got state=%0d match=%0b required %0d/0",
                        i, g, ia.state_o, ia.match, es[i]);
            end
         end
      end
      for (int g = 0; g < 2; g++) begin
         idle(1);
         checks++;
         if (ia.match !== 1'b0 || ia.match_cnt !== 8'd1 || ia.state_o !== 3'd4) begin
            errors++;
            $display("FAIL gap_after cycle%0d: got match=%0b cnt=%0d state=%0d required 0/1/4",
                     g, ia.match, ia.match_cnt, ia.state_o);
         end
      end
   endtask

   task automatic test_reload;
      logic [3:0] bits;
      int         es[4];
      bits = 4'b0110;
      es   = '{1, 2, 3, 4};
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      checks++;
      if (ia.state_o !== 3'd3) begin
         errors++;
         $display("FAIL reload_prefix: got state=%0d required 3", ia.state_o);
      end
      din_valid = 1'b1;
      din       = 1'b1;
      do_cfg(4'b0110, 1'b1, 1'b0);
      din_valid = 1'b0;
      din       = 1'b0;
      checks++;
      if (ia.state_o !== 3'd0 || ia.match !== 1'b0 || ia.match_cnt !== 8'd1) begin
         errors++;
         $display("FAIL reload_edge: got state=%0d match=%0b cnt=%0d required 0/0/1",
                  ia.state_o, ia.match, ia.match_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         send_bit(bits[3-i]);
         checks++;
         if (ia.state_o !== 3'(es[i]) || ia.match !== (i == 3)) begin
            errors++;
            $display("FAIL reload_step bit%0d: got state=%0d match=%0b required %0d/%0b",
                     i, ia.state_o, ia.match, es[i], (i == 3));
         end
      end
      checks++;
      if (ia.match_cnt !== 8'd2) begin
         errors++;
         $display("FAIL reload_cnt: got %0d required 2", ia.match_cnt);
      end
   endtask

   task automatic test_counter;
      int ec;
      int es;
      do_cfg(4'b1111, 1'b1, 1'b1);
      checks++;
      if (ib.match_cnt !== 2'd0 || ib.state_o !== 3'd0) begin
         errors++;
         $display("FAIL cnt_cfg: got cnt=%0d state=%0d required 0/0", ib.match_cnt, ib.state_o);
      end
      for (int i = 1; i <= 10; i++) begin
         send_bit(1'b1);
         ec = (i >= 4) ? i - 3 : 0;
         if (ec > 3) ec = 3;
         es = (i >= 4) ? 4 : i;
         checks++;
         if (ib.match_cnt !== 2'(ec) || ib.state_o !== 3'(es) || ib.match !== (i >= 4)) begin
            errors++;
            $display("FAIL cnt_sat bit%0d: got cnt=%0d state=%0d match=%0b required %0d/%0d/%0b",
                     i, ib.match_cnt, ib.state_o, ib.match, ec, es, (i >= 4));
         end
      end
      cnt_clr = 1'b1;
      send_bit(1'b1);
      cnt_clr = 1'b0;
      checks++;
      if (ib.match !== 1'b1 || ib.match_cnt !== 2'd0) begin
         errors++;
         $display("FAIL cnt_clr_wins: got match=%0b cnt=%0d required 1/0", ib.match, ib.match_cnt);
      end
   endtask

   task automatic test_back_to_back;
      send_bit(1'b1);
      checks++;
      if (ib.match !== 1'b1 || ib.match_cnt !== 2'd1) begin
         errors++;
         $display("FAIL b2b_next: got match=%0b cnt=%0d required 1/1", ib.match, ib.match_cnt);
      end
      idle(1);
      checks++;
      if (ib.match !== 1'b0 || ib.match_cnt !== 2'd1 || ib.state_o !== 3'd4) begin
         errors++;
         $display("FAIL b2b_idle: got match=%0b cnt=%0d state=%0d required 0/1/4",
                  ib.match, ib.match_cnt, ib.state_o);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      cfg_load    = 1'b0;
      cfg_pattern = 4'b0000;
      cfg_overlap = 1'b0;
      din_valid   = 1'b0;
      din         = 1'b0;
      cnt_clr     = 1'b0;
      idle(2);
      test_reset();
      test_overlap();
      test_non_overlap();
      test_valid_gaps();
      test_reload();
      test_counter();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
